clock_set_controller: RTL and testbench
=======================================

# clock_set_controller

Sequencing and time-set controller for the 24-hour BCD clock chain. Divides the system clock into the one-second enable that drives the seconds/minutes/hours counter chain. Runs a RUN / SET_HR / SET_MIN / COMMIT state machine driven by two push-button inputs. Issues a single-cycle parallel load of the edited hour and minute into the counter chain. The block sits between the user buttons and the counter chain and owns the chain's enable.

## Interface
- TICK_DIV, default 50_000_000: clk cycles per one-second tick; legal range ≥ 4, must be even.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; while low, all state is forced to reset values.
- mode_btn  in  1  mode button; already synchronized and debounced; level input, rising edge used.
- inc_btn  in  1  increment button; already synchronized and debounced; level input, rising edge used.
- cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min  in  4 each  live BCD time from the counter chain.
- tick_en  out  1  one-cycle enable to the counter chain's seconds stage.
- load  out  1  one-cycle strobe; the counter chain loads ld_* into hours/minutes and clears seconds to 00.
- ld_ms_hr, ld_ls_hr, ld_ms_min, ld_ls_min  out  4 each  edit registers; driven continuously.
- set_mode  out  2  current mode: 00 = RUN, 01 = SET_HR, 10 = SET_MIN, 11 = COMMIT.
- blink  out  1  display blink for the field being edited.

## Operation
- **Edge detect.** Each button has a 1-bit history register (reset value 0). An edge is "btn = 1 at this rising clk edge and btn = 0 at the previous one". Holding a button produces exactly one edge.
- **Prescaler.** cnt counts 0..TICK_DIV-1 and wraps. It increments every cycle in RUN, SET_HR and SET_MIN. It is forced to 0 in COMMIT.
- **tick_en.** tick_en = (state == RUN) && (cnt == TICK_DIV-1). It is never asserted outside RUN.
- **blink.** blink = (state is SET_HR or SET_MIN) && (cnt < TICK_DIV/2). It is 0 in RUN and COMMIT.
- **State transitions:**
  - RUN + mode edge → SET_HR. On the same edge, edit registers capture cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min.
  - SET_HR + mode edge → SET_MIN.
  - SET_HR + inc edge: hour increments in BCD. ls 9 → ls 0 with ms+1. 23 → 00.
  - SET_MIN + mode edge → COMMIT.
  - SET_MIN + inc edge: minute increments in BCD. ls 9 → ls 0 with ms+1. 59 → 00.
  - COMMIT: load = 1 for exactly this one cycle; unconditional → RUN on the next edge. Both buttons are ignored in COMMIT.
- **Simultaneous edges.** If mode and inc edges occur on the same clk edge, mode wins and inc is discarded.
- **Illegal captured values.** Hour > 23, minute > 59, or any BCD digit > 9 become 00 on the first increment of that field. Edit registers are otherwise unchecked.
- **Reset mid-operation.** reset low in any state → RUN. Edits are discarded and no load is issued.
- **Reset values:**
  - state RUN, set_mode 00.
  - cnt 0, tick_en 0, load 0, blink 0.
  - all ld_* 0.
  - button history registers 0.

## Timing
- **First tick after reset.** reset deasserts before edge 1. tick_en is high during the cycle after edge TICK_DIV-1, i.e. the cycle before edge TICK_DIV. After that it is high 1 cycle in every TICK_DIV.
- **Button latency.** set_mode updates on the same clk edge that detects the button edge (0 cycles added). Edit registers update on that same edge.
- **Load strobe.** load is high during the COMMIT cycle. ld_* are stable across that cycle.
- **First tick after commit.** The first tick_en after COMMIT occurs TICK_DIV cycles after leaving COMMIT (cnt restarts at 0). A full second therefore elapses before the loaded :00 seconds advances.
- **Counter chain while editing.** The chain is frozen in SET_HR and SET_MIN because tick_en = 0.
- **Outputs.** All outputs are glitch-free decodes of registers; there is no combinational path from inputs to outputs.

## Test plan
1. TICK_DIV = 4; release reset, hold buttons low → tick_en pulses on cycles 4, 8, 12; blink stays 0; set_mode stays 00.
2. cur time 22:58. Stimulus: mode, inc×2, mode, inc×2, mode → hour 22→23→00 and minute 58→59→00; a single load pulse with ld = 00:00; RUN resumes; next tick 4 cycles after COMMIT.
3. Hold mode_btn high for 10 cycles in RUN → exactly one transition to SET_HR; no further advance.
4. mode and inc rising on the same edge in SET_HR → set_mode becomes 10; hour unchanged.
5. Assert reset low while in SET_MIN with edited minute 37 → immediately set_mode = 00, ld_* = 0, load never pulses, cnt = 0.
6. cur time 27:75 (illegal) captured; one inc in SET_HR and one inc in SET_MIN → hour 00, minute 00.

Source files
------------

// File: rtl/clock_set_controller.sv
// clock_set_controller: one-second prescaler and time-set sequencer for the
// 24-hour BCD clock chain.
//   clk, reset (async, active-low)    clock and reset
//   mode_btn, inc_btn                 debounced, synchronized button levels
//   cur_{ms,ls}_{hr,min}              live BCD time from the counter chain
//   tick_en                           one-cycle seconds enable to the chain
//   load                              one-cycle parallel-load strobe to the chain
//   ld_{ms,ls}_{hr,min}               edit registers, driven continuously
//   set_mode                          00 RUN, 01 SET_HR, 10 SET_MIN, 11 COMMIT
//   blink                             display blink for the field being edited
module clock_set_controller #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_btn,
   input  logic       inc_btn,
   input  logic [3:0] cur_ms_hr,
   input  logic [3:0] cur_ls_hr,
   input  logic [3:0] cur_ms_min,
   input  logic [3:0] cur_ls_min,
   output logic       tick_en,
   output logic       load,
   output logic [3:0] ld_ms_hr,
   output logic [3:0] ld_ls_hr,
   output logic [3:0] ld_ms_min,
   output logic [3:0] ld_ls_min,
   output logic [1:0] set_mode,
   output logic       blink
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2);

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_SET_HR  = 2'b01,
      ST_SET_MIN = 2'b10,
      ST_COMMIT  = 2'b11
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             mode_q, inc_q;
   logic             mode_edge, inc_edge;
   logic [3:0]       ms_hr_n, ls_hr_n, ms_min_n, ls_min_n;
   logic             tick_n, load_n, blink_n;

   // Hour +1 in BCD; 23 and any illegal hour/digit roll to 00.
   function automatic logic [7:0] hr_inc(input logic [3:0] ms, input logic [3:0] ls);
      if ((ms > 4'd2) || (ls > 4'd9) || ((ms == 4'd2) && (ls >= 4'd3)))
         return 8'h00;
      else if (ls == 4'd9)
         return {ms + 4'd1, 4'd0};
      else
         return {ms, ls + 4'd1};
   endfunction

   // Minute +1 in BCD; 59 and any illegal minute/digit roll to 00.
   function automatic logic [7:0] min_inc(input logic [3:0] ms, input logic [3:0] ls);
      if ((ms > 4'd5) || (ls > 4'd9) || ((ms == 4'd5) && (ls == 4'd9)))
         return 8'h00;
      else if (ls == 4'd9)
         return {ms + 4'd1, 4'd0};
      else
         return {ms, ls + 4'd1};
   endfunction

   assign set_mode = state;

   // Next-state, edit-register and registered-output decode.
   always_comb begin
      mode_edge = mode_btn & ~mode_q;
      inc_edge  = inc_btn & ~inc_q;
      state_n   = state;
      ms_hr_n   = ld_ms_hr;
      ls_hr_n   = ld_ls_hr;
      ms_min_n  = ld_ms_min;
      ls_min_n  = ld_ls_min;

      case (state)
         ST_RUN: begin
            if (mode_edge) begin
               state_n  = ST_SET_HR;
               ms_hr_n  = cur_ms_hr;
               ls_hr_n  = cur_ls_hr;
               ms_min_n = cur_ms_min;
               ls_min_n = cur_ls_min;
            end
         end
         ST_SET_HR: begin
            // mode has priority; a coincident inc edge is dropped
            if (mode_edge)
               state_n = ST_SET_MIN;
            else if (inc_edge)
               {ms_hr_n, ls_hr_n} = hr_inc(ld_ms_hr, ld_ls_hr);
         end
         ST_SET_MIN: begin
            if (mode_edge)
               state_n = ST_COMMIT;
            else if (inc_edge)
               {ms_min_n, ls_min_n} = min_inc(ld_ms_min, ld_ls_min);
         end
         ST_COMMIT: state_n = ST_RUN;
         default:   state_n = ST_RUN;
      endcase

      // Prescaler is held at 0 through COMMIT so RUN restarts a full second.
      if ((state == ST_COMMIT) || (state_n == ST_COMMIT))
         cnt_n = '0;
      else if (cnt == CNT_MAX)
         cnt_n = '0;
      else
         cnt_n = cnt + CNT_W'(1);

      tick_n  = (state_n == ST_RUN) && (cnt_n == CNT_MAX);
      load_n  = (state_n == ST_COMMIT);
      blink_n = ((state_n == ST_SET_HR) || (state_n == ST_SET_MIN)) && (cnt_n < CNT_HALF);
   end

   // State, prescaler, button history, edit registers and output flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_RUN;
         cnt       <= '0;
         mode_q    <= 1'b0;
         inc_q     <= 1'b0;
         ld_ms_hr  <= 4'd0;
         ld_ls_hr  <= 4'd0;
         ld_ms_min <= 4'd0;
         ld_ls_min <= 4'd0;
         tick_en   <= 1'b0;
         load      <= 1'b0;
         blink     <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         mode_q    <= mode_btn;
         inc_q     <= inc_btn;
         ld_ms_hr  <= ms_hr_n;
         ld_ls_hr  <= ls_hr_n;
         ld_ms_min <= ms_min_n;
         ld_ls_min <= ls_min_n;
         tick_en   <= tick_n;
         load      <= load_n;
         blink     <= blink_n;
      end
   end

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboard bench for clock_set_controller with TICK_DIV = 4.
// Stimulus pushes hand-computed snapshots (keyed by rising-edge number since
// reset release) and expected load strobes; the monitor pops and compares.
module tb_clock_set_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       mode_btn, inc_btn;
   logic [3:0] cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min;
   logic       tick_en, load, blink;
   logic [3:0] ld_ms_hr, ld_ls_hr, ld_ms_min, ld_ls_min;
   logic [1:0] set_mode;

   clock_set_controller #(.TICK_DIV(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .mode_btn   (mode_btn),
      .inc_btn    (inc_btn),
      .cur_ms_hr  (cur_ms_hr),
      .cur_ls_hr  (cur_ls_hr),
      .cur_ms_min (cur_ms_min),
      .cur_ls_min (cur_ls_min),
      .tick_en    (tick_en),
      .load       (load),
      .ld_ms_hr   (ld_ms_hr),
      .ld_ls_hr   (ld_ls_hr),
      .ld_ms_min  (ld_ms_min),
      .ld_ls_min  (ld_ls_min),
      .set_mode   (set_mode),
      .blink      (blink)
   );

   always #5 clk = ~clk;

   // v = {set_mode[1:0], ld hh:mm BCD[15:0], tick_en, load, blink}
   typedef struct packed { int at; logic [20:0] v; } snap_t;
   typedef struct packed { int at; logic [15:0] ld; } ld_t;

   snap_t sq[$];
   ld_t   lq[$];
   int    edge_n;
   int    n_cmp = 0;
   int    n_fail = 0;
   logic  done = 1'b0;

   // Rising edges since reset release; after edge k this reads k.
   always @(posedge clk or negedge reset) begin
      if (!reset) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   task automatic ex(input logic [1:0] m, input logic [15:0] ld,
                     input logic t, input logic l, input logic b);
      snap_t e;
      e.at = edge_n + 1;
      e.v  = {m, ld, t, l, b};
      sq.push_back(e);
   endtask

   task automatic lx(input logic [15:0] ld);
      ld_t e;
      e.at = edge_n + 1;
      e.ld = ld;
      lq.push_back(e);
   endtask

   task automatic go(input logic m, input logic i);
      mode_btn = m;
      inc_btn  = i;
      @(negedge clk);
   endtask

   task automatic set_cur(input logic [15:0] t);
      {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min} = t;
   endtask

   // Monitor: compares due snapshots and every load strobe.
   initial begin
      snap_t       s;
      ld_t         l;
      logic [20:0] act;
      forever begin
         @(posedge clk);
         #1;
         act = {set_mode, ld_ms_hr, ld_ls_hr, ld_ms_min, ld_ls_min, tick_en, load, blink};
         if (sq.size() > 0 && sq[0].at < edge_n) begin
            s = sq.pop_front();
            n_cmp++; n_fail++;
            $display("FAIL snap_missed@%0d: now edge %0d", s.at, edge_n);
         end
         if (sq.size() > 0 && sq[0].at == edge_n) begin
            s = sq.pop_front();
            n_cmp++;
            if (act !== s.v) begin
               n_fail++;
               $display("FAIL snap@%0d: got mode=%b ld=%h tick=%b load=%b blink=%b, want mode=%b ld=%h tick=%b load=%b blink=%b",
                        s.at, act[20:19], act[18:3], act[2], act[1], act[0],
                        s.v[20:19], s.v[18:3], s.v[2], s.v[1], s.v[0]);
            end
         end
         if (load === 1'b1) begin
            n_cmp++;
            if (lq.size() == 0) begin
               n_fail++;
               $display("FAIL load_unexpected@%0d: got load=1 ld=%h, want no load", edge_n, act[18:3]);
            end else begin
               l = lq.pop_front();
               if (l.at != edge_n || act[18:3] !== l.ld) begin
                  n_fail++;
                  $display("FAIL load@%0d: got edge %0d ld=%h, want edge %0d ld=%h",
                           l.at, edge_n, act[18:3], l.at, l.ld);
               end
            end
         end
         if (done) begin
            n_cmp++;
            if (sq.size() != 0) begin
               n_fail++;
               $display("FAIL snaps_pending: got %0d left, want 0", sq.size());
            end
            n_cmp++;
            if (lq.size() != 0) begin
               n_fail++;
               $display("FAIL loads_pending: got %0d left, want 0", lq.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   // Stimulus; comments give the edge number each ex/go pair targets.
   initial begin
      snap_t r;
      reset = 1'b0;
      mode_btn = 1'b0;
      inc_btn = 1'b0;
      set_cur(16'h0000);
      r.at = 0; r.v = '0;
      sq.push_back(r);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Idle RUN: tick after edges 3, 7, 11; no blink, mode 00
      for (int k = 1; k <= 12; k++) begin
         ex(2'd0, 16'h0000, (k % 4 == 3), 1'b0, 1'b0); go(1'b0, 1'b0);
      end

      // Set 22:58 -> 00:00 with hour/minute wrap, then commit
      set_cur(16'h2258);
      ex(2'd1, 16'h2258, 1'b0, 1'b0, 1'b1); go(1'b1, 1'b0);   // 13 capture
      ex(2'd1, 16'h2358, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b1);   // 14
      ex(2'd1, 16'h2358, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b0);   // 15
      ex(2'd1, 16'h0058, 1'b0, 1'b0, 1'b1); go(1'b0, 1'b1);   // 16 23->00
      ex(2'd2, 16'h0058, 1'b0, 1'b0, 1'b1); go(1'b1, 1'b0);   // 17
      ex(2'd2, 16'h0059, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b1);   // 18
      ex(2'd2, 16'h0059, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b0);   // 19
      ex(2'd2, 16'h0000, 1'b0, 1'b0, 1'b1); go(1'b0, 1'b1);   // 20 59->00
      ex(2'd3, 16'h0000, 1'b0, 1'b1, 1'b0); lx(16'h0000);
      go(1'b1, 1'b0);                                         // 21 COMMIT
      ex(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b1);   // 22 RUN, inc ignored
      ex(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b0);   // 23
      ex(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b0);   // 24
      ex(2'd0, 16'h0000, 1'b1, 1'b0, 1'b0); go(1'b0, 1'b0);   // 25 first tick
      ex(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b0);   // 26

      // Hold mode for 10 edges (27..36): one step to SET_HR, no recapture
      set_cur(16'h1335);
      ex(2'd1, 16'h1335, 1'b0, 1'b0, 1'b1); go(1'b1, 1'b0);   // 27
      set_cur(16'h0000);
      for (int k = 28; k <= 36; k++) begin
         ex(2'd1, 16'h1335, 1'b0, 1'b0, ((k - 26) % 4) < 2); go(1'b1, 1'b0);
      end
      ex(2'd1, 16'h1335, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b0);   // 37

      // Simultaneous mode+inc in SET_HR: mode wins, hour unchanged
      ex(2'd2, 16'h1335, 1'b0, 1'b0, 1'b1); go(1'b1, 1'b1);   // 38
      ex(2'd2, 16'h1335, 1'b0, 1'b0, 1'b1); go(1'b0, 1'b0);   // 39
      ex(2'd2, 16'h1336, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b1);   // 40
      ex(2'd2, 16'h1336, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b0);   // 41
      ex(2'd2, 16'h1337, 1'b0, 1'b0, 1'b1); go(1'b0, 1'b1);   // 42 minute 37

      // Reset in SET_MIN: everything back to reset values, no load
      reset = 1'b0;
      mode_btn = 1'b0;
      inc_btn = 1'b0;
      r.at = 0; r.v = '0;
      sq.push_back(r);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         ex(2'd0, 16'h0000, (k == 3), 1'b0, 1'b0); go(1'b0, 1'b0);
      end

      // Illegal capture 27:75: first inc of each field gives 00
      set_cur(16'h2775);
      ex(2'd1, 16'h2775, 1'b0, 1'b0, 1'b1); go(1'b1, 1'b0);   // 5
      ex(2'd1, 16'h0075, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b1);   // 6
      ex(2'd2, 16'h0075, 1'b0, 1'b0, 1'b0); go(1'b1, 1'b0);   // 7
      ex(2'd2, 16'h0000, 1'b0, 1'b0, 1'b1); go(1'b0, 1'b1);   // 8
      ex(2'd3, 16'h0000, 1'b0, 1'b1, 1'b0); lx(16'h0000);
      go(1'b1, 1'b0);                                         // 9 COMMIT
      ex(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b0);   // 10
      ex(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b0);   // 11
      ex(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0); go(1'b0, 1'b0);   // 12
      ex(2'd0, 16'h0000, 1'b1, 1'b0, 1'b0); go(1'b0, 1'b0);   // 13 tick
      go(1'b0, 1'b0);
      go(1'b0, 1'b0);
      done = 1'b1;
   end

endmodule
